// File: rtl/modulo_mef_controle_registrador.sv
`default_nettype none
// ============================================================================
// Module   : modulo_mef_controle_registrador
// Brief    : FIFO buffer of user operands feeding the counter FSM handshake.
// Revision : 1.0 - initial release
// ============================================================================
module modulo_mef_controle_registrador #(
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  store,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  Load_C,
   input  logic                  Clear_Reg,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  Load_Reg,
   output logic                  EmptyBuffer,
   output logic                  FullBuffer,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  q1,
   output logic                  q0
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PRESENT = 2'b01,
      HOLD    = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] c_ZERO_COUNT = '0;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q;
   logic [ADDR_WIDTH:0]     count_q;
   logic [DATA_WIDTH-1:0]   data_out_q;
   logic                    store_prev_q;
   logic                    overflow_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic w_rise;
   logic w_pop;
   logic w_full;
   logic w_wr;
   logic w_drop;

   assign w_rise = enable & store & ~store_prev_q;
   assign w_pop  = enable & (state_q == HOLD) & Clear_Reg;
   assign w_full = (count_q == c_FULL_COUNT);
   // A pop in the same cycle frees the head slot, so a full buffer still accepts.
   assign w_wr   = w_rise & (~w_full | w_pop);
   assign w_drop = w_rise & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         store_prev_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else if (enable) begin
         store_prev_q <= store;
         overflow_q   <= w_drop;

         if (w_wr) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end

         case ({w_wr, w_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         case (state_q)
            IDLE: begin
               if (count_q != c_ZERO_COUNT) begin
                  state_q    <= PRESENT;
                  data_out_q <= mem_q[rd_ptr_q];
               end
            end
            PRESENT: begin
               if (Load_C) begin
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (Clear_Reg) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_out    = data_out_q;
   assign Load_Reg    = (state_q == PRESENT) || (state_q == HOLD);
   assign EmptyBuffer = (count_q == c_ZERO_COUNT);
   assign FullBuffer  = (count_q == c_FULL_COUNT);
   assign overflow    = overflow_q;
   assign count       = count_q;
   assign q1          = state_q[1];
   assign q0          = state_q[0];

endmodule
`default_nettype wire

// File: tb/tb_modulo_mef_controle_registrador.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulo_mef_controle_registrador
// Brief    : Scoreboard bench for the operand FIFO / counter handshake block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_mef_controle_registrador;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       store;
   logic [3:0] data_in;
   logic       Load_C;
   logic       Clear_Reg;
   logic [3:0] data_out;
   logic       Load_Reg;
   logic       EmptyBuffer;
   logic       FullBuffer;
   logic       overflow;
   logic [2:0] count;
   logic       q1;
   logic       q0;

   int checks   = 0;
   int failures = 0;
   int ovf_seen = 0;

   logic [3:0] exp_q [$];
   logic       prev_lr = 1'b0;
   logic [3:0] held_val = 4'h0;

   modulo_mef_controle_registrador #(
      .DATA_WIDTH (4),
      .DEPTH      (4),
      .ADDR_WIDTH (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .store       (store),
      .data_in     (data_in),
      .Load_C      (Load_C),
      .Clear_Reg   (Clear_Reg),
      .data_out    (data_out),
      .Load_Reg    (Load_Reg),
      .EmptyBuffer (EmptyBuffer),
      .FullBuffer  (FullBuffer),
      .overflow    (overflow),
      .count       (count),
      .q1          (q1),
      .q0          (q0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] v, input bit accepted);
      data_in = v;
      if (accepted) exp_q.push_back(v);
      store = 1'b1;
      tick();
      store = 1'b0;
      tick();
   endtask

   task automatic wait_lr();
      for (int i = 0; i < 20 && !Load_Reg; i++) tick();
      chk("load_reg_timeout", int'(Load_Reg), 1);
   endtask

   task automatic serve();
      wait_lr();
      Load_C = 1'b1;
      tick();
      Load_C = 1'b0;
      Clear_Reg = 1'b1;
      tick();
      Clear_Reg = 1'b0;
   endtask

   // Monitor: each new presentation pops the scoreboard; held values must not move.
   always @(negedge clk) begin
      if (rst) begin
         prev_lr = 1'b0;
      end else begin
         if (overflow) ovf_seen++;
         if (Load_Reg && !prev_lr) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_present", int'(data_out), 16);
            end else begin
               chk("present_data", int'(data_out), int'(exp_q.pop_front()));
            end
            held_val = data_out;
         end else if (Load_Reg && prev_lr) begin
            chk("data_out_stable", int'(data_out), int'(held_val));
         end
         prev_lr = Load_Reg;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = 1'b1; store = 1'b0; data_in = 4'h0;
      Load_C = 1'b0; Clear_Reg = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_load_reg", int'(Load_Reg), 0);
      chk("rst_empty", int'(EmptyBuffer), 1);
      chk("rst_full", int'(FullBuffer), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_state", int'({q1, q0}), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_overflow", int'(overflow), 0);

      // Single transfer with store held for three cycles
      data_in = 4'h7; exp_q.push_back(4'h7); store = 1'b1;
      tick();
      chk("single_count1", int'(count), 1);
      chk("single_lr_early", int'(Load_Reg), 0);
      tick();
      chk("single_lr", int'(Load_Reg), 1);
      chk("single_data", int'(data_out), 7);
      chk("single_present", int'({q1, q0}), 1);
      tick();
      store = 1'b0;
      chk("single_one_write", int'(count), 1);
      Load_C = 1'b1; tick(); Load_C = 1'b0;
      chk("single_hold", int'({q1, q0}), 2);
      Clear_Reg = 1'b1; tick(); Clear_Reg = 1'b0;
      chk("single_lr_clear", int'(Load_Reg), 0);
      chk("single_empty", int'(EmptyBuffer), 1);

      // Ordering across the pointer wrap
      press(4'h3, 1); press(4'h5, 1); press(4'h9, 1); press(4'hC, 1);
      chk("order_full", int'(FullBuffer), 1);
      repeat (4) serve();
      press(4'h1, 1); press(4'h2, 1);
      repeat (2) serve();
      tick();
      chk("order_empty", int'(EmptyBuffer), 1);
      chk("order_no_overflow", ovf_seen, 0);

      // Full buffer and dropped write
      press(4'h4, 1); press(4'h6, 1); press(4'h8, 1); press(4'hA, 1);
      chk("full_flag", int'(FullBuffer), 1);
      chk("full_count", int'(count), 4);
      data_in = 4'hF; store = 1'b1;
      tick();
      chk("ovf_pulse", int'(overflow), 1);
      chk("ovf_count", int'(count), 4);
      store = 1'b0;
      tick();
      chk("ovf_pulse_end", int'(overflow), 0);
      chk("ovf_count_after", int'(count), 4);

      // Write and pop in the same cycle while full
      Load_C = 1'b1; tick(); Load_C = 1'b0;
      chk("sim_hold", int'({q1, q0}), 2);
      data_in = 4'h7; exp_q.push_back(4'h7);
      store = 1'b1; Clear_Reg = 1'b1;
      tick();
      store = 1'b0; Clear_Reg = 1'b0;
      chk("sim_count", int'(count), 4);
      chk("sim_no_overflow", int'(overflow), 0);
      chk("sim_idle", int'({q1, q0}), 0);
      repeat (4) serve();
      tick();
      chk("sim_drained", int'(count), 0);
      chk("ovf_total", ovf_seen, 1);

      // Enable freeze in PRESENT
      press(4'h5, 1);
      wait_lr();
      enable = 1'b0;
      data_in = 4'h9; store = 1'b1; Load_C = 1'b1;
      tick();
      store = 1'b0; tick();
      store = 1'b1; tick();
      Load_C = 1'b0; store = 1'b0; tick();
      chk("frz_state", int'({q1, q0}), 1);
      chk("frz_count", int'(count), 1);
      chk("frz_data", int'(data_out), 5);
      enable = 1'b1;
      tick();
      chk("frz_resume_state", int'({q1, q0}), 1);
      chk("frz_no_capture", int'(count), 1);
      serve();
      tick();
      chk("frz_empty", int'(EmptyBuffer), 1);

      // Asynchronous reset with three entries and the FSM in HOLD
      press(4'h1, 1); press(4'h2, 1); press(4'h3, 1);
      wait_lr();
      Load_C = 1'b1; tick(); Load_C = 1'b0;
      chk("pre_rst_state", int'({q1, q0}), 2);
      chk("pre_rst_count", int'(count), 3);
      #2 rst = 1'b1;
      #1;
      chk("arst_load_reg", int'(Load_Reg), 0);
      chk("arst_empty", int'(EmptyBuffer), 1);
      chk("arst_count", int'(count), 0);
      chk("arst_state", int'({q1, q0}), 0);
      chk("arst_data_out", int'(data_out), 0);
      exp_q.delete();

      // store held high across reset release counts as one press
      data_in = 4'hB; store = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.push_back(4'hB);
      tick();
      chk("rel_press_count", int'(count), 1);
      store = 1'b0;
      serve();
      tick();
      chk("rel_empty", int'(EmptyBuffer), 1);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/modulo_mef_controle_registrador.md
Name: modulo_mef_controle_registrador

Overview:
Producer-side control for the counter datapath. It captures operand values entered by the user into a small FIFO buffer and presents them one at a time to the counter control FSM. It drives the Load_Reg and EmptyBuffer handshake outputs. It consumes Load_C, which means the counter has taken the value, and Clear_Reg, which means the counter has finished with it and the head entry is released.

Parameters:
DATA_WIDTH, 4, width of each stored value.
DEPTH, 4, number of buffer entries; must be a power of 2 and at least 2.
ADDR_WIDTH, 2, log2(DEPTH); width of the read and write pointers.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  global advance; when 0, all registers hold their value.
store  input  1  user "store" level signal (debounced upstream); each rising edge is one write request.
data_in  input  DATA_WIDTH  value written on a store rising edge.
Load_C  input  1  from the counter FSM: the counter is loading data_out.
Clear_Reg  input  1  from the counter FSM: the counter is done; release the head entry.
data_out  output  DATA_WIDTH  head value presented to the counter.
Load_Reg  output  1  a presented value is valid and owned by the counter.
EmptyBuffer  output  1  buffer holds zero entries.
FullBuffer  output  1  buffer holds DEPTH entries.
overflow  output  1  one-cycle pulse: a write request was dropped because the buffer was full.
count  output  ADDR_WIDTH+1  number of buffered entries, 0..DEPTH.
q1  output  1  FSM state bit 1 (MSB), for debug.
q0  output  1  FSM state bit 0 (LSB), for debug.

Behaviour:
- Reset (asynchronous):
  - state = IDLE (q1q0 = 00).
  - Pointers, count, data_out, store_d, overflow all = 0.
  - Therefore Load_Reg = 0, EmptyBuffer = 1, FullBuffer = 0.
  - Reset mid-handshake discards all buffered entries; no pop is signalled.
- enable = 0: every register holds; store rises occurring while enable = 0 are not captured later.
- Edge detect:
  - store_d <= store when enable = 1.
  - rise = store & ~store_d & enable.
  - store held high through reset release counts as one press.
- Write:
  - On a rise with count < DEPTH: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping modulo DEPTH; count increments.
  - On a rise with count == DEPTH: nothing is written; overflow = 1 for exactly the next cycle.
- Flags:
  - EmptyBuffer = (count == 0) and FullBuffer = (count == DEPTH), decoded from registered count (no combinational path from inputs).
- FSM states, encoded as q1q0:
  - IDLE (00): if count != 0, go to PRESENT and latch data_out <= mem[rd_ptr]; otherwise stay.
  - PRESENT (01): Load_Reg = 1. If Load_C = 1, go to HOLD. Clear_Reg is ignored here.
  - HOLD (10): Load_Reg = 1. If Clear_Reg = 1, then rd_ptr increments (wrapping), count decrements, and the next state is IDLE. Load_C is ignored.
  - State 11 is illegal; the next state is IDLE with no pop.
- Load_Reg = (state == PRESENT) or (state == HOLD), registered-state decode.
- data_out:
  - Stable for the whole time Load_Reg = 1.
  - Keeps its last value after the pop until the next PRESENT.
- Latency:
  - A rise sampled at edge k with the buffer empty gives count = 1 after edge k and Load_Reg = 1 after edge k+1.
  - Clear_Reg sampled at edge m gives Load_Reg = 0 after edge m.
  - The next entry, if any, is presented after edge m+1 (one IDLE cycle minimum between values).
- Simultaneous write and pop in the same cycle: both occur, count is unchanged, and the write is accepted even if count == DEPTH at that edge.
- Load_C or Clear_Reg asserted in IDLE: ignored.
- Load_C and Clear_Reg both high in PRESENT: go to HOLD only; Clear_Reg takes effect on a later cycle.
- Pointer wrap: after DEPTH writes, wr_ptr returns to 0. FIFO ordering is preserved across the wrap.

Test Plan:
- Reset check: assert rst mid-run with 3 entries and state HOLD -> immediately Load_Reg = 0, EmptyBuffer = 1, count = 0, q1q0 = 00, data_out = 0.
- Single transfer: data_in = 4'h7, pulse store for 3 cycles -> exactly one write, count = 1. Load_Reg = 1 and data_out = 7 two edges after the rise. Then Load_C = 1 -> q1q0 = 10. Then Clear_Reg = 1 -> Load_Reg = 0, EmptyBuffer = 1.
- Ordering and wrap: write 3, 5, 9, C, pop all four, then write 1, 2 and pop both -> data_out sequence 3, 5, 9, C, 1, 2; no overflow.
- Full and overflow: write 4 values, then a 5th press with data_in = F -> FullBuffer = 1, overflow pulses for one cycle, count stays 4, F never appears on data_out.
- Simultaneous write and pop: count = 4 in HOLD, store rise and Clear_Reg in the same cycle -> count stays 4, no overflow, the new value appears last.
- Enable freeze: enable = 0 with the FSM in PRESENT, toggle store and Load_C -> state, count and data_out unchanged. After enable = 1, behaviour resumes from PRESENT.
